// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the main decoder.
//
// Owns the PC and runs a single-outstanding req/ack fetch from instruction
// memory. A fetched word is held (with its op_code split out) until the
// decode stage consumes it. The decoder's branch/jump results for the held
// word, plus the ALU condition and target, then select the next PC, or stop
// fetch on an illegal opcode or a misaligned redirect.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   imem_req_o          fetch request valid
//   imem_addr_o         fetch address (= PC)
//   imem_ack_i          memory accepts request; imem_rdata_i valid same cycle
//   imem_rdata_i        instruction word
//   instr_valid_o       instr_o / instr_pc_o / op_code_o hold a valid word
//   instr_ready_i       decode consumes the held word this cycle
//   instr_o             held instruction word
//   instr_pc_o          address of the held word
//   op_code_o           instr_o[6:0]
//   branch_i            decoder branch flag for the held word
//   jump_i              2'b01 seq, 2'b10 jal, 2'b11 illegal, 2'b00 seq
//   cond_i              branch condition from the ALU
//   target_i            branch/jal target
//   halted_o            fetch stopped until reset
//   halt_cause_o        2'b00 none, 2'b01 illegal opcode, 2'b10 misaligned
//   instret_o           count of consumed instructions

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [6:0]  op_code_o,
  input  logic        branch_i,
  input  logic [1:0]  jump_i,
  input  logic        cond_i,
  input  logic [31:0] target_i,
  output logic        halted_o,
  output logic [1:0]  halt_cause_o,
  output logic [31:0] instret_o
);

  typedef enum logic [1:0] {StStart, StFetch, StHold, StHalt} state_e;

  localparam logic [1:0] JumpJal     = 2'b10;
  localparam logic [1:0] JumpIllegal = 2'b11;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseAlign   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;

  logic redirect;

  assign redirect = (jump_i == JumpJal) || (branch_i && cond_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StStart;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      instret_q <= 32'h0;
      cause_q   <= CauseNone;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    cause_d   = cause_q;

    unique case (state_q)
      StStart: state_d = StFetch;

      // imem_ack_i is only looked at here, so stray acks elsewhere are inert.
      StFetch: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = StHold;
        end
      end

      // Control inputs only matter on the consume edge. On a halt the PC is
      // left on the offending instruction so it can be inspected afterwards.
      StHold: begin
        if (instr_ready_i) begin
          instret_d = instret_q + 32'd1;
          if (jump_i == JumpIllegal) begin
            cause_d = CauseIllegal;
            state_d = StHalt;
          end else if (redirect && (target_i[1:0] != 2'b00)) begin
            cause_d = CauseAlign;
            state_d = StHalt;
          end else if (redirect) begin
            pc_d    = target_i;
            state_d = StFetch;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
          end
        end
      end

      StHalt: state_d = StHalt;

      default: state_d = StStart;
    endcase
  end

  assign imem_req_o    = (state_q == StFetch);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == StHold);
  assign instr_o       = instr_q;
  assign instr_pc_o    = pc_q;
  assign op_code_o     = instr_q[6:0];
  assign halted_o      = (state_q == StHalt);
  assign halt_cause_o  = cause_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized
// stream, all checked against a behavioural model of the fetch stage
// (expected PC, retire count and halt status). Inputs change and outputs are
// sampled on the falling clock edge.

module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [6:0]  op_code_o;
  logic        branch_i;
  logic [1:0]  jump_i;
  logic        cond_i;
  logic [31:0] target_i;
  logic        halted_o;
  logic [1:0]  halt_cause_o;
  logic [31:0] instret_o;

  fetch_unit #(
    .RESET_PC(RstPc)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .op_code_o    (op_code_o),
    .branch_i     (branch_i),
    .jump_i       (jump_i),
    .cond_i       (cond_i),
    .target_i     (target_i),
    .halted_o     (halted_o),
    .halt_cause_o (halt_cause_o),
    .instret_o    (instret_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic        m_halted;
  logic [1:0]  m_cause;

  // Deterministic instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RstPc;
    m_instret = 32'd0;
    m_halted  = 1'b0;
    m_cause   = 2'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req"}, imem_req_o, 1'b0);
    chk({tag, "_addr"}, imem_addr_o, RstPc);
    chk1({tag, "_valid"}, instr_valid_o, 1'b0);
    chk({tag, "_opcode"}, {25'd0, op_code_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc_o, RstPc);
    chk1({tag, "_halted"}, halted_o, 1'b0);
    chk({tag, "_cause"}, {30'd0, halt_cause_o}, 32'd0);
    chk({tag, "_instret"}, instret_o, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk_reset_outputs("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_i = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk1("req_seen", imem_req_o, 1'b1);
  endtask

  // One instruction: fetch with ack_dly wait states, hold for rdy_dly cycles
  // with junk on the control inputs, then consume with the given controls.
  task automatic step(input int ack_dly, input int rdy_dly, input logic [1:0] j,
                      input logic b, input logic c, input logic [31:0] t);
    logic [31:0] w;
    logic        redir;
    wait_req();
    chk("fetch_addr", imem_addr_o, m_pc);
    chk1("valid_in_fetch", instr_valid_o, 1'b0);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = $urandom;
      @(negedge clk_i);
      chk1("req_held", imem_req_o, 1'b1);
      chk("addr_held", imem_addr_o, m_pc);
    end
    w            = mem_word(m_pc);
    imem_ack_i   = 1'b1;
    imem_rdata_i = w;
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    chk1("valid_after_ack", instr_valid_o, 1'b1);
    chk1("req_in_hold", imem_req_o, 1'b0);
    chk("instr", instr_o, w);
    chk("op_code", {25'd0, op_code_o}, {25'd0, w[6:0]});
    chk("instr_pc", instr_pc_o, m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready_i = 1'b0;
      imem_ack_i    = 1'($urandom_range(0, 1));
      imem_rdata_i  = $urandom;
      jump_i        = 2'($urandom_range(0, 3));
      branch_i      = 1'($urandom_range(0, 1));
      cond_i        = 1'($urandom_range(0, 1));
      target_i      = $urandom;
      @(negedge clk_i);
      chk1("valid_hold", instr_valid_o, 1'b1);
      chk("instr_stable", instr_o, w);
      chk("instret_hold", instret_o, m_instret);
    end
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b1;
    jump_i        = j;
    branch_i      = b;
    cond_i        = c;
    target_i      = t;
    @(negedge clk_i);
    instr_ready_i = 1'b0;
    // Model: consume retires the instruction, then pick next PC or halt.
    m_instret = m_instret + 32'd1;
    redir     = (j == 2'b10) || (b && c);
    if (j == 2'b11) begin
      m_halted = 1'b1;
      m_cause  = 2'b01;
    end else if (redir && (t % 4 != 0)) begin
      m_halted = 1'b1;
      m_cause  = 2'b10;
    end else if (redir) begin
      m_pc = t;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    chk("instret", instret_o, m_instret);
    chk1("halted", halted_o, m_halted);
    chk("halt_cause", {30'd0, halt_cause_o}, {30'd0, m_cause});
    chk1("valid_after_consume", instr_valid_o, 1'b0);
    chk1("req_after_consume", imem_req_o, !m_halted);
    chk("next_addr", imem_addr_o, m_pc);
  endtask

  task automatic check_halt_sticks();
    for (int i = 0; i < 3; i++) begin
      imem_ack_i    = 1'b1;
      instr_ready_i = 1'b1;
      @(negedge clk_i);
      chk1("halt_no_req", imem_req_o, 1'b0);
      chk1("halt_stays", halted_o, 1'b1);
      chk("halt_addr", imem_addr_o, m_pc);
      chk("halt_instret", instret_o, m_instret);
    end
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  rj;
    logic [31:0] rt;
    int          r;
    rst_i         = 1'b0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'd0;
    instr_ready_i = 1'b0;
    branch_i      = 1'b0;
    jump_i        = 2'b01;
    cond_i        = 1'b0;
    target_i      = 32'd0;
    model_reset();

    // Startup and sequential stream with wait states, then illegal opcode.
    apply_reset();
    step(0, 0, 2'b01, 1'b0, 1'b0, 32'h0);
    apply_reset();
    step(2, 3, 2'b01, 1'b0, 1'b0, 32'h0);
    step(2, 3, 2'b01, 1'b1, 1'b0, 32'h300);
    step(2, 3, 2'b00, 1'b0, 1'b1, 32'h400);
    chk("instret_three", instret_o, 32'd3);
    step(0, 1, 2'b11, 1'b1, 1'b1, 32'h200);
    chk("illegal_addr", imem_addr_o, 32'h10C);
    check_halt_sticks();

    // Taken branch, not-taken branch, jal, misaligned redirect.
    apply_reset();
    step(0, 0, 2'b01, 1'b0, 1'b0, 32'h0);
    step(1, 0, 2'b01, 1'b1, 1'b1, 32'h200);
    chk("branch_taken", imem_addr_o, 32'h200);
    apply_reset();
    step(0, 0, 2'b01, 1'b0, 1'b0, 32'h0);
    step(0, 2, 2'b01, 1'b1, 1'b0, 32'h200);
    chk("branch_not_taken", imem_addr_o, 32'h108);
    step(0, 0, 2'b10, 1'b0, 1'b0, 32'h40);
    chk("jal", imem_addr_o, 32'h40);
    step(1, 1, 2'b01, 1'b1, 1'b1, 32'h202);
    chk("misaligned_cause", {30'd0, halt_cause_o}, 32'd2);
    check_halt_sticks();

    // PC wrap-around.
    apply_reset();
    step(0, 0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(0, 0, 2'b01, 1'b0, 1'b0, 32'h0);
    chk("pc_wrap", imem_addr_o, 32'h0);
    step(0, 0, 2'b01, 1'b0, 1'b0, 32'h0);

    // Reset while waiting for ack, late ack after release.
    apply_reset();
    step(0, 0, 2'b10, 1'b0, 1'b0, 32'h800);
    wait_req();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk_reset_outputs("midfetch");
    @(negedge clk_i);
    model_reset();
    rst_i        = 1'b0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    chk1("late_ack_valid", instr_valid_o, 1'b0);
    chk("late_ack_instr", instr_o, 32'd0);
    chk("restart_addr", imem_addr_o, RstPc);
    step(1, 0, 2'b01, 1'b0, 1'b0, 32'h0);

    // Randomized stream.
    for (int k = 0; k < 150; k++) begin
      if (m_halted) apply_reset();
      r = int'($urandom_range(0, 15));
      if (r == 0)     rj = 2'b11;
      else if (r < 5) rj = 2'b10;
      else if (r < 7) rj = 2'b00;
      else            rj = 2'b01;
      rt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rt = rt | 32'(1 + $urandom_range(0, 2));
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rj,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
